// File: rtl/core_writeback_arbiter_pkg.sv
// Shared micro-architecture types for the writeback path: register/word widths,
// register-file write line and execution-unit result descriptors.
package core_writeback_arbiter_pkg;
    localparam int WORD_W     = 32;
    localparam int NUM_GPREGS = 32;
    localparam int REG_W      = $clog2(NUM_GPREGS);

    typedef logic [WORD_W-1:0] word;
    typedef logic [REG_W-1:0]  reg_num;

    localparam reg_num R0 = '0;

    typedef struct packed {
        logic   ready;
        reg_num rd;
        word    value;
    } wb_line;

    typedef struct packed {
        logic   valid;
        reg_num rd;
        word    value;
    } wb_src;

    function automatic wb_line idle_line();
        wb_line l;
        l.ready = 1'b0;
        l.rd    = R0;
        l.value = '0;
        return l;
    endfunction
endpackage

// File: rtl/core_writeback_pick.sv
// Rotated-priority picker: first candidate at or after i_ptr (wrapping) whose
// destination register differs from i_excl_rd when exclusion is enabled.
module core_writeback_pick
    import core_writeback_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         i_cand,
    input  logic [$clog2(NUM_SRC)-1:0] i_ptr,
    input  logic                       i_excl_en,
    input  reg_num                     i_excl_rd,
    input  reg_num [NUM_SRC-1:0]       i_rd,
    output logic [NUM_SRC-1:0]         o_grant,
    output logic                       o_found,
    output logic [$clog2(NUM_SRC)-1:0] o_idx
);
    localparam int PW = $clog2(NUM_SRC);

    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            idx = int'(i_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!o_found && i_cand[idx] && (!i_excl_en || i_rd[idx] != i_excl_rd)) begin
                o_found      = 1'b1;
                o_grant[idx] = 1'b1;
                o_idx        = PW'(idx);
            end
        end
    end
endmodule

// File: rtl/core_writeback_arbiter.sv
// Writeback arbiter: picks up to two results per cycle by round-robin, drops R0
// writes, and registers them onto the two register-file write ports.
module core_writeback_arbiter
    import core_writeback_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  reg_num [NUM_SRC-1:0] src_rd,
    input  word [NUM_SRC-1:0]    src_value,
    output logic [NUM_SRC-1:0]   src_ready,
    output wb_line               wr_a,
    output wb_line               wr_b
);
    localparam int PW = $clog2(NUM_SRC);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_SRC - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [PW-1:0]      r_rr_ptr;
    wb_line             r_wr_a;
    wb_line             r_wr_b;

    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_r0_ack;
    logic [NUM_SRC-1:0] w_grant_a;
    logic [NUM_SRC-1:0] w_grant_b;
    logic               w_found_a;
    logic               w_found_b;
    logic [PW-1:0]      w_idx_a;
    logic [PW-1:0]      w_idx_b;
    logic [PW-1:0]      w_ptr_nxt;
    wb_line             w_line_a;
    wb_line             w_line_b;

    always_comb begin
        w_cand   = '0;
        w_r0_ack = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_cand[i]   = src_valid[i] && (src_rd[i] != R0);
            w_r0_ack[i] = src_valid[i] && (src_rd[i] == R0);
        end
    end

    core_writeback_pick #(.NUM_SRC(NUM_SRC)) u_pick_a (
        .i_cand    (w_cand),
        .i_ptr     (r_rr_ptr),
        .i_excl_en (1'b0),
        .i_excl_rd (R0),
        .i_rd      (src_rd),
        .o_grant   (w_grant_a),
        .o_found   (w_found_a),
        .o_idx     (w_idx_a)
    );

    // Slot B never shares a destination with slot A, so same-rd results stay ordered.
    core_writeback_pick #(.NUM_SRC(NUM_SRC)) u_pick_b (
        .i_cand    (w_cand & ~w_grant_a),
        .i_ptr     (r_rr_ptr),
        .i_excl_en (w_found_a),
        .i_excl_rd (src_rd[w_idx_a]),
        .i_rd      (src_rd),
        .o_grant   (w_grant_b),
        .o_found   (w_found_b),
        .o_idx     (w_idx_b)
    );

    always_comb begin
        src_ready = rst ? '0 : (w_r0_ack | w_grant_a | w_grant_b);

        w_line_a = idle_line();
        w_line_b = idle_line();
        if (w_found_a) begin
            w_line_a.ready = 1'b1;
            w_line_a.rd    = src_rd[w_idx_a];
            w_line_a.value = src_value[w_idx_a];
        end
        if (w_found_b) begin
            w_line_b.ready = 1'b1;
            w_line_b.rd    = src_rd[w_idx_b];
            w_line_b.value = src_value[w_idx_b];
        end

        w_ptr_nxt = r_rr_ptr;
        if (w_found_b)      w_ptr_nxt = ptr_inc(w_idx_b);
        else if (w_found_a) w_ptr_nxt = ptr_inc(w_idx_a);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_wr_a   <= idle_line();
            r_wr_b   <= idle_line();
        end else begin
            r_rr_ptr <= w_ptr_nxt;
            r_wr_a   <= w_line_a;
            r_wr_b   <= w_line_b;
        end
    end

    assign wr_a = r_wr_a;
    assign wr_b = r_wr_b;
endmodule

// File: tb/tb_core_writeback_arbiter.sv
// Directed and randomized bench for core_writeback_arbiter against a queue-based
// reference model of the round-robin writeback rules.
module tb_core_writeback_arbiter;
    import core_writeback_arbiter_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   src_valid;
    reg_num [N-1:0] src_rd;
    word [N-1:0]    src_value;
    logic [N-1:0]   src_ready;
    wb_line         wr_a;
    wb_line         wr_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    core_writeback_arbiter #(.NUM_SRC(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_rd    (src_rd),
        .src_value (src_value),
        .src_ready (src_ready),
        .wr_a      (wr_a),
        .wr_b      (wr_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list valid non-R0 sources in rotated order; A is the head,
    // B the first later entry with a different destination register.
    task automatic model(output logic [N-1:0] rdy, output int ia, output int ib);
        int order[$];
        rdy = '0;
        ia  = -1;
        ib  = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (src_valid[j] && src_rd[j] == 0) rdy[j] = 1'b1;
            if (src_valid[j] && src_rd[j] != 0) order.push_back(j);
        end
        if (order.size() > 0) begin
            ia = order[0];
            for (int k = 1; k < order.size(); k++)
                if (ib < 0 && src_rd[order[k]] != src_rd[ia]) ib = order[k];
        end
        if (ia >= 0) rdy[ia] = 1'b1;
        if (ib >= 0) rdy[ib] = 1'b1;
        if (rst) begin
            rdy = '0;
            ia  = -1;
            ib  = -1;
        end
    endtask

    task automatic cycle(output logic [N-1:0] acc, output logic [N-1:0] seen);
        logic [N-1:0] er;
        int ia, ib;
        wb_line ea, eb;
        #1;
        model(er, ia, ib);
        seen = src_ready;
        chk("src_ready", src_ready, er);
        ea = '0;
        eb = '0;
        if (ia >= 0) ea = {1'b1, src_rd[ia], src_value[ia]};
        if (ib >= 0) eb = {1'b1, src_rd[ib], src_value[ib]};
        acc = er;
        @(posedge clk);
        #1;
        chk("wr_a", wr_a, ea);
        chk("wr_b", wr_b, eb);
        if (rst)          m_ptr = 0;
        else if (ib >= 0) m_ptr = (ib + 1) % N;
        else if (ia >= 0) m_ptr = (ia + 1) % N;
    endtask

    task automatic set_src(input int i, input logic v, input int rd, input logic [31:0] val);
        src_valid[i] = v;
        src_rd[i]    = reg_num'(rd);
        src_value[i] = val;
    endtask

    initial begin
        logic [N-1:0] acc, seen;

        // Reset held with every source valid
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_src(i, 1'b1, i + 1, 32'h11 * (i + 1));
        for (int c = 0; c < 3; c++) begin
            cycle(acc, seen);
            chk("rst_ready", seen, 4'b0000);
            chk("rst_wr_a", wr_a, 38'h0);
            chk("rst_wr_b", wr_b, 38'h0);
        end
        rst = 1'b0;

        // Distinct destinations: two grants per cycle
        cycle(acc, seen);
        chk("dist1_ready", seen, 4'b0011);
        chk("dist1_a", wr_a, {1'b1, 5'd1, 32'h11});
        chk("dist1_b", wr_b, {1'b1, 5'd2, 32'h22});
        for (int i = 0; i < N; i++) if (acc[i]) src_valid[i] = 1'b0;
        cycle(acc, seen);
        chk("dist2_a", wr_a, {1'b1, 5'd3, 32'h33});
        chk("dist2_b", wr_b, {1'b1, 5'd4, 32'h44});
        for (int i = 0; i < N; i++) if (acc[i]) src_valid[i] = 1'b0;
        cycle(acc, seen);
        chk("idle_a_ready", wr_a.ready, 1'b0);
        chk("idle_b_ready", wr_b.ready, 1'b0);

        // Same-rd conflict: one grant, second source follows next cycle
        set_src(0, 1'b1, 5, 32'hA);
        set_src(1, 1'b1, 5, 32'hB);
        cycle(acc, seen);
        chk("conf_ready", seen, 4'b0001);
        chk("conf_a", wr_a, {1'b1, 5'd5, 32'hA});
        chk("conf_b_ready", wr_b.ready, 1'b0);
        src_valid[0] = 1'b0;
        cycle(acc, seen);
        chk("conf2_a", wr_a, {1'b1, 5'd5, 32'hB});
        src_valid[1] = 1'b0;

        // R0 filter alongside a real write
        set_src(2, 1'b1, 0, 32'hDEAD);
        set_src(3, 1'b1, 7, 32'h77);
        cycle(acc, seen);
        chk("r0_ready", seen, 4'b1100);
        chk("r0_a", wr_a, {1'b1, 5'd7, 32'h77});
        chk("r0_b_ready", wr_b.ready, 1'b0);
        src_valid = '0;

        // Fairness: everyone targets r9, grants rotate 0,1,2,3,0
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 9, 32'h900 + i);
        for (int c = 0; c < 5; c++) begin
            cycle(acc, seen);
            chk("fair_ready", seen, 4'b0001 << (c % N));
            chk("fair_a_rd", wr_a.rd, 5'd9);
            for (int i = 0; i < N; i++) if (acc[i]) src_value[i] = src_value[i] + 32'h10;
        end
        src_valid = '0;

        // Reset mid-operation
        for (int i = 0; i < 3; i++) set_src(i, 1'b1, i + 1, 32'h100 + i);
        cycle(acc, seen);
        rst = 1'b1;
        cycle(acc, seen);
        chk("mid_rst_ready", seen, 4'b0000);
        chk("mid_rst_a_ready", wr_a.ready, 1'b0);
        chk("mid_rst_b_ready", wr_b.ready, 1'b0);
        rst = 1'b0;
        cycle(acc, seen);
        chk("post_rst_ready", seen, 4'b0011);
        chk("post_rst_a_rd", wr_a.rd, 5'd1);

        // Randomized traffic with a small rd range to provoke R0 and conflicts
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            cycle(acc, seen);
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !src_valid[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_src(i, 1'b1, $urandom_range(0, 5), $urandom);
                    else
                        src_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
